// File: rtl/mem_arbiter_llsc.sv
// Shared single-port RAM arbiter between an instruction-fetch port and a data
// port, with LL/SC reservation tracking.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   if_req/if_addr       fetch request (held until if_ack)
//   if_ack/if_rdata      fetch completion pulse and data
//   mem_req/mem_we/mem_ll/mem_sc/mem_addr/mem_sel/mem_wdata
//                        data request (held until mem_ack)
//   mem_ack/mem_rdata    data completion pulse and load data
//   mem_sc_ok            SC outcome, valid with mem_ack
//   llbit_clr/llbit      reservation flush input, current reservation bit
//   ram_ce/ram_we/ram_addr/ram_sel/ram_wdata
//                        registered RAM command
//   ram_rdata            RAM read data, one cycle after the command
//
// Every access is IDLE (grant) -> ACCESS (RAM command) -> RESP (ack).

module mem_arbiter_llsc #(
  parameter int unsigned RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_ll,
  input  logic              mem_sc,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic              mem_sc_ok,
  input  logic              llbit_clr,
  output logic              llbit,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;

  // Round-robin pointer: 0 favours MEM, 1 favours IF.
  logic ptr_q, ptr_d;

  // Attributes of the granted access, captured at the grant edge.
  logic        gnt_mem_q, gnt_mem_d;
  logic        gnt_we_q, gnt_we_d;
  logic        gnt_ll_q, gnt_ll_d;
  logic        gnt_sc_q, gnt_sc_d;
  logic        sc_ok_q, sc_ok_d;
  logic [29:0] gnt_addr_q, gnt_addr_d;

  // Reservation.
  logic        llbit_q, llbit_d;
  logic [29:0] link_q, link_d;

  // RAM command registers.
  logic              ram_ce_q, ram_ce_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic        grant;
  logic        grant_mem;
  logic        sc_pass;
  logic [31:0] req_addr;
  logic        unused_addr_bits;

  always_comb begin
    grant     = (state_q == StIdle) && (if_req || mem_req);
    // MEM wins when alone or when the pointer favours it.
    grant_mem = mem_req && (!if_req || !ptr_q);
    req_addr  = grant_mem ? mem_addr : if_addr;
    // A flush arriving together with the SC grant kills the SC.
    sc_pass   = llbit_q && (link_q == mem_addr[31:2]) && !llbit_clr;
  end

  assign unused_addr_bits = ^req_addr[1:0];

  // Next-state, grant capture and RAM command.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_mem_d   = gnt_mem_q;
    gnt_we_d    = gnt_we_q;
    gnt_ll_d    = gnt_ll_q;
    gnt_sc_d    = gnt_sc_q;
    sc_ok_d     = sc_ok_q;
    gnt_addr_d  = gnt_addr_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d    = StAccess;
          ptr_d      = ~ptr_q;
          gnt_mem_d  = grant_mem;
          gnt_addr_d = req_addr[31:2];
          ram_addr_d = req_addr[RAM_AW+1:2];
          if (grant_mem) begin
            gnt_we_d    = mem_we;
            gnt_ll_d    = mem_ll;
            gnt_sc_d    = mem_sc;
            sc_ok_d     = mem_sc && sc_pass;
            // A failing SC keeps the RAM disabled so nothing is written.
            ram_ce_d    = !(mem_sc && !sc_pass);
            ram_we_d    = mem_we;
            ram_sel_d   = mem_sel;
            ram_wdata_d = mem_wdata;
          end else begin
            gnt_we_d    = 1'b0;
            gnt_ll_d    = 1'b0;
            gnt_sc_d    = 1'b0;
            sc_ok_d     = 1'b0;
            ram_ce_d    = 1'b1;
            ram_we_d    = 1'b0;
            ram_sel_d   = 4'hF;
            ram_wdata_d = 32'h0;
          end
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reservation update at the end of a data RESP; the flush has last word.
  always_comb begin
    llbit_d = llbit_q;
    link_d  = link_q;
    if ((state_q == StResp) && gnt_mem_q) begin
      if (gnt_ll_q) begin
        llbit_d = 1'b1;
        link_d  = gnt_addr_q;
      end
      if (gnt_sc_q && sc_ok_q) begin
        llbit_d = 1'b0;
      end else if (gnt_we_q && !gnt_sc_q && (gnt_addr_q == link_q)) begin
        llbit_d = 1'b0;
      end
    end
    if (llbit_clr) begin
      llbit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      gnt_mem_q   <= 1'b0;
      gnt_we_q    <= 1'b0;
      gnt_ll_q    <= 1'b0;
      gnt_sc_q    <= 1'b0;
      sc_ok_q     <= 1'b0;
      gnt_addr_q  <= '0;
      llbit_q     <= 1'b0;
      link_q      <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_mem_q   <= gnt_mem_d;
      gnt_we_q    <= gnt_we_d;
      gnt_ll_q    <= gnt_ll_d;
      gnt_sc_q    <= gnt_sc_d;
      sc_ok_q     <= sc_ok_d;
      gnt_addr_q  <= gnt_addr_d;
      llbit_q     <= llbit_d;
      link_q      <= link_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    if_ack    = (state_q == StResp) && !gnt_mem_q;
    mem_ack   = (state_q == StResp) && gnt_mem_q;
    mem_sc_ok = mem_ack && gnt_sc_q && sc_ok_q;
    if_rdata  = ram_rdata;
    mem_rdata = ram_rdata;
    llbit     = llbit_q;
    ram_ce    = ram_ce_q;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_sel   = ram_sel_q;
    ram_wdata = ram_wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter_llsc.sv
// Self-checking bench for mem_arbiter_llsc: a transaction-timing model of the
// arbiter plus directed LL/SC scenarios with hand-computed results.

module tb_mem_arbiter_llsc;

  localparam int unsigned AW    = 15;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, mem_req, mem_we, mem_ll, mem_sc, llbit_clr;
  logic [31:0]   if_addr, mem_addr, mem_wdata;
  logic [3:0]    mem_sel;
  logic          if_ack, mem_ack, mem_sc_ok, llbit, ram_ce, ram_we;
  logic [31:0]   if_rdata, mem_rdata, ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_sel;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] tb_ram [WORDS];
  logic [31:0] gold   [WORDS];

  mem_arbiter_llsc #(.RAM_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ll(mem_ll), .mem_sc(mem_sc),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_sc_ok(mem_sc_ok),
    .llbit_clr(llbit_clr), .llbit(llbit),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM device.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_sel[b]) tb_ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= tb_ram[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access granted at the end of cycle g has its RAM command in g+1 and
  // its ack in g+2; the model holds one outstanding access at most.
  logic        m_busy = 0, m_mem = 0, m_we = 0, m_isll = 0, m_sc = 0, m_ok = 0;
  logic        m_ll = 0, m_ptr = 0;
  logic [29:0] m_addr = 0, m_link = 0;
  logic [3:0]  m_sel = 0;
  logic [31:0] m_wd = 0;
  int          m_g = 0;

  task automatic model_edge();
    logic gm;
    if (m_busy && cyc == m_g + 1 && m_mem && m_we && (!m_sc || m_ok)) begin
      for (int b = 0; b < 4; b++) begin
        if (m_sel[b]) gold[m_addr[AW-1:0]][8*b +: 8] = m_wd[8*b +: 8];
      end
    end
    if (m_busy && cyc == m_g + 2) begin
      if (m_mem) begin
        if (m_isll) begin
          m_ll   = 1'b1;
          m_link = m_addr;
        end
        if (m_sc && m_ok) m_ll = 1'b0;
        if (m_we && !m_sc && m_addr == m_link) m_ll = 1'b0;
      end
      m_busy = 1'b0;
    end else if (!m_busy && (if_req || mem_req)) begin
      gm     = mem_req && (!if_req || !m_ptr);
      m_ptr  = !m_ptr;
      m_busy = 1'b1;
      m_g    = cyc;
      m_mem  = gm;
      if (gm) begin
        m_we   = mem_we;
        m_isll = mem_ll;
        m_sc   = mem_sc;
        m_addr = mem_addr[31:2];
        m_sel  = mem_sel;
        m_wd   = mem_wdata;
        m_ok   = mem_sc && m_ll && (m_link == mem_addr[31:2]) && !llbit_clr;
      end else begin
        m_we   = 1'b0;
        m_isll = 1'b0;
        m_sc   = 1'b0;
        m_ok   = 1'b0;
        m_addr = if_addr[31:2];
      end
    end
    if (llbit_clr) m_ll = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset_n) model_edge();
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge reset_n);
      m_busy = 1'b0;
      m_ll   = 1'b0;
      m_link = '0;
      m_ptr  = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_sel", 32'(ram_sel), 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_mem_ack", mem_ack, 0);
        chk("rst_sc_ok", mem_sc_ok, 0);
        chk("rst_llbit", llbit, 0);
        chk("rst_if_rdata", if_rdata, ram_rdata);
        chk("rst_mem_rdata", mem_rdata, ram_rdata);
      end else begin : cmp
        logic acc, rsp;
        acc = m_busy && (cyc == m_g + 1);
        rsp = m_busy && (cyc == m_g + 2);
        chk("ram_ce", ram_ce, acc && !(m_sc && !m_ok));
        chk("ram_we", ram_we, acc && m_mem && m_we);
        chk("mem_ack", mem_ack, rsp && m_mem);
        chk("if_ack", if_ack, rsp && !m_mem);
        chk("mem_sc_ok", mem_sc_ok, rsp && m_mem && m_sc && m_ok);
        chk("llbit", llbit, m_ll);
        if (acc) chk("ram_addr", 32'(ram_addr), 32'(m_addr[AW-1:0]));
        if (acc && m_mem) begin
          chk("ram_sel", 32'(ram_sel), 32'(m_sel));
          chk("ram_wdata", ram_wdata, m_wd);
        end
        if (rsp && !m_we) begin
          chk("rdata", m_mem ? mem_rdata : if_rdata, gold[m_addr[AW-1:0]]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic mem_op(input logic we, input logic ll, input logic sc,
                        input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input logic clr_resp,
                        output logic ok, output logic [31:0] rd,
                        output int ack_cyc, output logic saw_ce);
    mem_req = 1'b1; mem_we = we; mem_ll = ll; mem_sc = sc;
    mem_addr = addr; mem_sel = sel; mem_wdata = wd;
    ack_cyc = -1; ok = 1'b0; rd = 32'h0; saw_ce = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (ram_ce) saw_ce = 1'b1;
      if (mem_ack) begin
        ok = mem_sc_ok; rd = mem_rdata; ack_cyc = cyc;
        break;
      end
    end
    mem_req = 1'b0; mem_we = 1'b0; mem_ll = 1'b0; mem_sc = 1'b0;
    if (ack_cyc < 0) chk("mem_ack_timeout", 0, 1);
    if (clr_resp) begin
      llbit_clr = 1'b1;
      @(posedge clk); #2;
      llbit_clr = 1'b0;
    end
  endtask

  task automatic if_op(input logic [31:0] addr, output logic [31:0] rd,
                       output int ack_cyc, output logic [31:0] acc_addr,
                       output logic acc_we);
    if_req = 1'b1; if_addr = addr;
    ack_cyc = -1; rd = 32'h0; acc_addr = 32'hFFFF_FFFF; acc_we = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (ram_ce) begin
        acc_addr = 32'(ram_addr);
        acc_we   = ram_we;
      end
      if (if_ack) begin
        rd = if_rdata; ack_cyc = cyc;
        break;
      end
    end
    if_req = 1'b0;
    if (ack_cyc < 0) chk("if_ack_timeout", 0, 1);
  endtask

  task automatic idle1();
    @(posedge clk); #2;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    logic        ok, ce, we_seen;
    logic [31:0] rd, rd2, aa;
    int          r, m1, m2, i1, i2, t0, ac;

    for (int i = 0; i < WORDS; i++) begin
      tb_ram[i] = 32'h5000_0000 | i;
      gold[i]   = 32'h5000_0000 | i;
    end
    tb_ram[4] = 32'h3C01_1234;
    gold[4]   = 32'h3C01_1234;

    reset_n = 1'b0; llbit_clr = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_ll = 1'b0; mem_sc = 1'b0;
    mem_addr = 32'h0; mem_sel = 4'h0; mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ram_ce", ram_ce, 0);
    chk("reset_llbit", llbit, 0);

    // Both requesters from reset release: MEM first, then strict alternation.
    r = cyc;
    reset_n = 1'b1;
    fork
      begin
        mem_op(0, 0, 0, 32'h20, 4'hF, 0, 0, ok, rd, m1, ce);
        chk("rr_mem1_rdata", rd, 32'h5000_0008);
        mem_op(0, 0, 0, 32'h24, 4'hF, 0, 0, ok, rd2, m2, ce);
      end
      begin
        if_op(32'h10, rd, i1, aa, we_seen);
        if_op(32'h14, rd2, i2, aa, we_seen);
      end
    join
    chk("rr_mem_first_lat", 32'(m1 - r), 2);
    chk("rr_if_after_mem", 32'(i1 - m1), 3);
    chk("rr_mem_after_if", 32'(m2 - i1), 3);
    chk("rr_if_again", 32'(i2 - m2), 3);

    // Plain fetch of word 4.
    idle1();
    t0 = cyc;
    if_op(32'h0000_0010, rd, ac, aa, we_seen);
    chk("fetch_rdata", rd, 32'h3C01_1234);
    chk("fetch_latency", 32'(ac - t0), 2);
    chk("fetch_ram_addr", aa, 4);
    chk("fetch_ram_we", we_seen, 0);

    // LL then SC to the same word succeeds.
    idle1();
    mem_op(0, 1, 0, 32'h100, 4'hF, 0, 0, ok, rd, ac, ce);
    chk("ll_rdata", rd, 32'h5000_0040);
    idle1();
    chk("ll_sets_llbit", llbit, 1);
    mem_op(1, 0, 1, 32'h100, 4'hF, 32'hA5A5_A5A5, 0, ok, rd, ac, ce);
    chk("sc_ok", ok, 1);
    chk("sc_ram_ce", ce, 1);
    idle1();
    chk("sc_clears_llbit", llbit, 0);
    chk("sc_ram_word", tb_ram[32'h40], 32'hA5A5_A5A5);

    // A plain store to the linked word breaks the reservation.
    mem_op(0, 1, 0, 32'h100, 4'hF, 0, 0, ok, rd, ac, ce);
    mem_op(1, 0, 0, 32'h100, 4'b0011, 32'h1111_2222, 0, ok, rd, ac, ce);
    idle1();
    chk("store_clears_llbit", llbit, 0);
    mem_op(1, 0, 1, 32'h100, 4'hF, 32'hDEAD_BEEF, 0, ok, rd, ac, ce);
    chk("sc_after_store_ok", ok, 0);
    chk("sc_after_store_ce", ce, 0);
    idle1();
    chk("sc_after_store_word", tb_ram[32'h40], 32'hA5A5_2222);

    // A store to a different word keeps the reservation.
    mem_op(0, 1, 0, 32'h200, 4'hF, 0, 0, ok, rd, ac, ce);
    mem_op(1, 0, 0, 32'h204, 4'hF, 32'h0BAD_F00D, 0, ok, rd, ac, ce);
    idle1();
    chk("other_store_keeps_llbit", llbit, 1);
    mem_op(1, 0, 1, 32'h200, 4'hF, 32'h7777_8888, 0, ok, rd, ac, ce);
    chk("sc_other_ok", ok, 1);
    idle1();
    chk("sc_other_word", tb_ram[32'h80], 32'h7777_8888);
    chk("store_other_word", tb_ram[32'h81], 32'h0BAD_F00D);

    // Flush during the LL's RESP wins over the LL set.
    mem_op(0, 1, 0, 32'h100, 4'hF, 0, 1, ok, rd, ac, ce);
    chk("flush_llbit", llbit, 0);
    mem_op(1, 0, 1, 32'h100, 4'hF, 32'h1234_5678, 0, ok, rd, ac, ce);
    chk("flush_sc_ok", ok, 0);
    idle1();
    chk("flush_sc_word", tb_ram[32'h40], 32'hA5A5_2222);

    // Reset during the ACCESS cycle of a store aborts it.
    repeat (2) idle1();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h180; mem_sel = 4'hF;
    mem_wdata = 32'h1234_5678;
    idle1();
    chk("abort_in_access", ram_ce, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ram_ce", ram_ce, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_addr", 32'(ram_addr), 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle1();
      chk("abort_no_ack", mem_ack, 0);
    end
    chk("abort_ram_word", tb_ram[32'h60], 32'h5000_0060);

    // RAM content survives the reset.
    mem_op(0, 0, 0, 32'h100, 4'hF, 0, 0, ok, rd, ac, ce);
    chk("post_reset_load", rd, 32'hA5A5_2222);
    repeat (3) idle1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter_llsc.md
MEM_ARBITER_LLSC -- requirements
Module: mem_arbiter_llsc

Interface
REQ-001 Parameter RAM_AW, default 15: word-address width of the shared RAM.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_ack  output  1  one-cycle pulse, fetch complete, if_rdata valid.
REQ-007 if_rdata  output  32  fetched word.
REQ-008 mem_req  input  1  data request; held with all mem_* inputs until mem_ack.
REQ-009 mem_we  input  1  1 = store, 0 = load.
REQ-010 mem_ll  input  1  load is load-linked (LL); valid only with mem_we=0.
REQ-011 mem_sc  input  1  store is store-conditional (SC); valid only with mem_we=1.
REQ-012 mem_addr  input  32  data byte address.
REQ-013 mem_sel  input  4  byte enables for stores.
REQ-014 mem_wdata  input  32  store data.
REQ-015 mem_ack  output  1  one-cycle pulse, data access complete.
REQ-016 mem_rdata  output  32  load data, valid with mem_ack.
REQ-017 mem_sc_ok  output  1  valid with mem_ack for an SC: 1 = written, 0 = failed.
REQ-018 llbit_clr  input  1  exception/ERET flush; clears the reservation.
REQ-019 llbit  output  1  current reservation bit.
REQ-020 ram_ce, ram_we  output  1 each  registered RAM enable and write enable.
REQ-021 ram_addr  output  RAM_AW  registered word address = addr[RAM_AW+1:2].
REQ-022 ram_sel  output  4  registered byte enables; ram_wdata  output  32  registered store data.
REQ-023 ram_rdata  input  32  RAM read data, valid the cycle after the edge that samples ram_ce.

Function
REQ-024 FSM states IDLE, ACCESS, RESP; ACCESS and RESP each last exactly one cycle.
REQ-025 IDLE with any request: grant at the clock edge, register ram_* for the granted requester, go to ACCESS.
REQ-026 ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally; requests are not sampled in ACCESS or RESP.
REQ-027 In RESP, the granted requester's ack is 1 for that cycle only; rdata = ram_rdata (combinational pass-through).
REQ-028 Latency: request first high in IDLE in cycle N -> ack in cycle N+2; minimum spacing between acks is 3 cycles.
REQ-029 Arbitration: only one requester -> grant it; both -> round-robin via a 1-bit pointer toggled on every grant; pointer favors MEM after reset.
REQ-030 ram_ce is 1 only in ACCESS; ram_we = granted mem_we in ACCESS, else 0; fetches always have ram_we=0.
REQ-031 LL completion (mem_ack for mem_ll=1): llbit <= 1, link <= mem_addr[31:2].
REQ-032 SC grant with llbit=1 and link == mem_addr[31:2]: write performed, mem_sc_ok=1 in RESP, llbit <= 0 at end of RESP.
REQ-033 SC grant otherwise: ram_ce stays 0 in ACCESS (no write), mem_sc_ok=0 in RESP; timing unchanged.
REQ-034 A plain store completing to an address equal to link clears llbit.
REQ-035 llbit_clr=1 clears llbit at the next edge in any state; it overrides a same-cycle LL set.
REQ-036 llbit_clr is sampled at SC grant (IDLE edge): if asserted, the SC fails.
REQ-037 mem_sc_ok = 0 whenever mem_ack = 0 or the access is not an SC.

Reset
REQ-038 While reset_n=0: state IDLE; llbit, link, and pointer (favor MEM) = 0; ram_ce, ram_we, ram_sel, ram_addr, ram_wdata = 0; if_ack, mem_ack, mem_sc_ok = 0; rdata outputs = ram_rdata.
REQ-039 Reset asserted mid-access aborts it: no ack is issued and the requester must reissue after reset_n rises.

Verification
REQ-040 Fetch only, if_addr=0x0000_0010, RAM word 4 = 0x3C01_1234 -> if_ack two cycles later, if_rdata=0x3C01_1234, ram_addr=4, ram_we=0.
REQ-041 if_req and mem_req both high from reset release -> MEM granted first, IF second; acks 3 cycles apart, then alternation continues.
REQ-042 LL 0x100, then SC 0x100 with wdata 0xA5A5_A5A5 -> mem_sc_ok=1, RAM word 0x40 written, llbit=0.
REQ-043 LL 0x100, plain store 0x100, then SC 0x100 -> mem_sc_ok=0, ram_ce never 1 for the SC, RAM word unchanged.
REQ-044 LL 0x100 with llbit_clr pulsed in its RESP cycle -> llbit stays 0; following SC fails.
REQ-045 reset_n low during ACCESS of a store -> outputs return to reset values immediately; no mem_ack.
